// File: rtl/audio_pll_reset_sequencer_if.sv
// Signal bundle between the audio PLL reset sequencer and the PLL / downstream audio logic.
//
// Signals:
//   locked      - PLL lock, asynchronous to the sequencer clock
//   pll_rst     - active-high reset to the PLL
//   out_reset_n - qualified active-low reset for codec / I2S logic
//   lock_lost   - one-cycle pulse when lock drops while running
//   fail        - sticky retry-limit failure flag
//   retries     - failed lock attempts since last successful release (saturating)
//
// Modports:
//   master - the sequencer (consumes locked, drives everything else)
//   slave  - the PLL / downstream side
interface audio_pll_reset_sequencer_if;

   logic       locked;
   logic       pll_rst;
   logic       out_reset_n;
   logic       lock_lost;
   logic       fail;
   logic [3:0] retries;

   modport master (
      input  locked,
      output pll_rst,
      output out_reset_n,
      output lock_lost,
      output fail,
      output retries
   );

   modport slave (
      output locked,
      input  pll_rst,
      input  out_reset_n,
      input  lock_lost,
      input  fail,
      input  retries
   );

endinterface

// File: rtl/audio_pll_reset_sequencer.sv
// Audio PLL reset sequencer, 50 MHz reference-clock domain.
//
// Issues a timed PLL reset, waits for lock with a timeout-and-retry policy, debounces lock,
// then releases a qualified active-low reset to the audio logic. Loss of lock while running
// forces a full re-sequence.
//
// Ports:
//   clk     - reference clock (same net as the PLL refclk)
//   reset_n - asynchronous active-low reset
//   pll     - audio_pll_reset_sequencer_if.master (locked in; pll_rst, out_reset_n,
//             lock_lost, fail, retries out; all outputs registered)
//
// Parameters:
//   RST_CYCLES    - cycles pll_rst is held high per attempt (>= 2)
//   LOCK_TIMEOUT  - cycles to wait for lock before retrying
//   STABLE_CYCLES - consecutive synchronized-lock cycles required before release
//   MAX_RETRIES   - failed attempts before fail (1..15, only with the retry limit)
//
// Build option:
//   AUDIO_PLL_SEQ_RETRY_LIMIT_EN - when defined, compiles in the FAIL state and the
//   MAX_RETRIES limit. When undefined, retries continue forever and fail is tied low.
module audio_pll_reset_sequencer #(
   parameter int unsigned RST_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT  = 65536,
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned MAX_RETRIES   = 4
) (
   input logic                         clk,
   input logic                         reset_n,
   audio_pll_reset_sequencer_if.master pll
);

   localparam int unsigned MaxRstTo  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int unsigned MaxCycles = (MaxRstTo > STABLE_CYCLES) ? MaxRstTo : STABLE_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

   localparam logic [CntW-1:0] RstLast     = CntW'(RST_CYCLES - 1);
   localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
   localparam logic [CntW-1:0] StableLast  = CntW'(STABLE_CYCLES - 1);

   // Parameter sanity, seen only by simulation.
   always_comb begin
      assert (RST_CYCLES >= 2 && MAX_RETRIES >= 1 && MAX_RETRIES <= 15);
   end

`ifdef AUDIO_PLL_SEQ_RETRY_LIMIT_EN
   localparam logic [3:0] RetryLimit = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {
      StRst,
      StWait,
      StStab,
      StRun,
      StFail
   } state_e;
`else
   typedef enum logic [1:0] {
      StRst,
      StWait,
      StStab,
      StRun
   } state_e;
`endif

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            sync1_q;
   logic            locked_s;
   logic            pll_rst_q, pll_rst_d;
   logic            out_reset_n_q, out_reset_n_d;
   logic            lock_lost_q, lock_lost_d;
   logic [3:0]      retries_q, retries_d;
   logic [3:0]      retries_inc;
`ifdef AUDIO_PLL_SEQ_RETRY_LIMIT_EN
   logic            fail_q, fail_d;
`endif

   // Two-flop synchronizer; locked_s is the only consumer of the raw lock input.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q  <= 1'b0;
         locked_s <= 1'b0;
      end else begin
         sync1_q  <= pll.locked;
         locked_s <= sync1_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StRst;
         cnt_q         <= '0;
         pll_rst_q     <= 1'b1;
         out_reset_n_q <= 1'b0;
         lock_lost_q   <= 1'b0;
         retries_q     <= 4'd0;
`ifdef AUDIO_PLL_SEQ_RETRY_LIMIT_EN
         fail_q        <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         pll_rst_q     <= pll_rst_d;
         out_reset_n_q <= out_reset_n_d;
         lock_lost_q   <= lock_lost_d;
         retries_q     <= retries_d;
`ifdef AUDIO_PLL_SEQ_RETRY_LIMIT_EN
         fail_q        <= fail_d;
`endif
      end
   end

   assign retries_inc = (retries_q == 4'hF) ? 4'hF : retries_q + 4'd1;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q + 1'b1;
      pll_rst_d     = pll_rst_q;
      out_reset_n_d = out_reset_n_q;
      lock_lost_d   = 1'b0;
      retries_d     = retries_q;
`ifdef AUDIO_PLL_SEQ_RETRY_LIMIT_EN
      fail_d        = fail_q;
`endif

      unique case (state_q)
         StRst: begin
            pll_rst_d     = 1'b1;
            out_reset_n_d = 1'b0;
            if (cnt_q == RstLast) begin
               state_d   = StWait;
               cnt_d     = '0;
               pll_rst_d = 1'b0;
            end
         end

         StWait: begin
            pll_rst_d     = 1'b0;
            out_reset_n_d = 1'b0;
            // Lock takes priority over a coincident timeout.
            if (locked_s) begin
               state_d = StStab;
               cnt_d   = '0;
            end else if (cnt_q == TimeoutLast) begin
               retries_d = retries_inc;
               cnt_d     = '0;
               pll_rst_d = 1'b1;
               state_d   = StRst;
`ifdef AUDIO_PLL_SEQ_RETRY_LIMIT_EN
               if (retries_inc == RetryLimit) begin
                  state_d = StFail;
                  fail_d  = 1'b1;
               end
`endif
            end
         end

         StStab: begin
            if (!locked_s) begin
               // Fresh timeout window; a bounce is not a failed attempt.
               state_d = StWait;
               cnt_d   = '0;
            end else if (cnt_q == StableLast) begin
               state_d       = StRun;
               cnt_d         = '0;
               out_reset_n_d = 1'b1;
               retries_d     = 4'd0;
            end
         end

         StRun: begin
            out_reset_n_d = 1'b1;
            cnt_d         = cnt_q;
            if (!locked_s) begin
               state_d       = StRst;
               cnt_d         = '0;
               pll_rst_d     = 1'b1;
               out_reset_n_d = 1'b0;
               lock_lost_d   = 1'b1;
            end
         end

`ifdef AUDIO_PLL_SEQ_RETRY_LIMIT_EN
         StFail: begin
            cnt_d         = cnt_q;
            pll_rst_d     = 1'b1;
            out_reset_n_d = 1'b0;
            fail_d        = 1'b1;
         end
`endif

         default: begin
            state_d   = StRst;
            cnt_d     = '0;
            pll_rst_d = 1'b1;
         end
      endcase
   end

   assign pll.pll_rst     = pll_rst_q;
   assign pll.out_reset_n = out_reset_n_q;
   assign pll.lock_lost   = lock_lost_q;
   assign pll.retries     = retries_q;
`ifdef AUDIO_PLL_SEQ_RETRY_LIMIT_EN
   assign pll.fail        = fail_q;
`else
   assign pll.fail        = 1'b0;
`endif

endmodule

// File: doc/audio_pll_reset_sequencer.md
# audio_pll_reset_sequencer

Drives the audio PLL's active-high `rst` input and consumes its asynchronous `locked` output. Runs in the 50 MHz reference-clock domain. Issues a timed PLL reset, waits for lock with a timeout-and-retry policy, and debounces lock. Only then releases a qualified active-low reset (`out_reset_n`) to the audio codec/I2S logic, and re-sequences automatically on loss of lock.

## Interface
- `RST_CYCLES`, 16: cycles `pll_rst` is held high per reset attempt (≥2).
- `LOCK_TIMEOUT`, 65536: cycles to wait for lock before retrying (1.31 ms at 50 MHz).
- `STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before release.
- `MAX_RETRIES`, 4: failed attempts before `fail` (used only with the macro; 1..15).
- `clk` in 1: 50 MHz reference clock, same net as the PLL `refclk`.
- `reset_n` in 1: asynchronous, active-low reset.
- `locked` in 1: PLL lock, asynchronous to `clk`.
- `pll_rst` out 1: active-high reset to the PLL.
- `out_reset_n` out 1: qualified active-low reset for downstream audio logic.
- `lock_lost` out 1: one-cycle pulse when lock drops in RUN.
- `fail` out 1: sticky retry-limit failure flag.
- `retries` out 4: failed-attempt count since last RUN, saturating at 15.

## Operation
- `locked` passes through a 2-flop synchronizer; `locked_s` is the second flop. No other logic samples the raw input.
- One shared down-counter or up-counter, width `$clog2` of the largest of the three cycle parameters, plus 1.
- Reset values: state RST, counter 0, `pll_rst`=1, `out_reset_n`=0, `lock_lost`=0, `fail`=0, `retries`=0, sync flops 0.
- All outputs are registered; no output is decoded combinationally from state.
- RST:
  - `pll_rst`=1, counter increments.
  - At count RST_CYCLES−1 → WAIT, counter cleared.
- WAIT:
  - `pll_rst`=0.
  - If `locked_s`=1 → STAB, counter cleared.
  - Otherwise, at count LOCK_TIMEOUT−1: `retries` increments (saturating), then → RST, or → FAIL if the macro is enabled and the incremented value equals MAX_RETRIES.
  - `locked_s` rising on the same cycle as the timeout: lock wins → STAB, no increment.
- STAB:
  - If `locked_s`=0 → WAIT, counter cleared (fresh timeout window, no retry increment).
  - At count STABLE_CYCLES−1 with `locked_s`=1 → RUN; `out_reset_n`=1 and `retries` cleared on that same edge.
- RUN:
  - `out_reset_n`=1.
  - `locked_s`=0 → RST: `out_reset_n`=0, `pll_rst`=1, and `lock_lost`=1 for exactly one cycle, all on the same edge.
- FAIL: `pll_rst`=1, `out_reset_n`=0, `fail`=1. Terminal until `reset_n` is asserted.
- `reset_n` asserted in any state: all outputs go to their reset values immediately (asynchronous), and sequencing restarts from RST after release.

## Timing
- After `reset_n` release, `pll_rst` stays high for exactly RST_CYCLES rising edges.
- Lock-to-release latency: `locked` rising, sampled at edge k (with no WAIT/STAB disturbance) gives:
  - STAB entered at edge k+2;
  - `out_reset_n` high at edge k+2+STABLE_CYCLES.
- Loss-of-lock latency: `locked` falling, sampled at edge j, gives `out_reset_n` low, `pll_rst` high and `lock_lost` high at edge j+2.
- Timeout: WAIT entered at edge w with no lock gives RST (or FAIL) at edge w+LOCK_TIMEOUT.
- Glitches on `locked` shorter than one `clk` period may or may not be seen. A glitch seen in STAB restarts WAIT; a glitch seen in RUN forces a full re-sequence.

## Configuration
- `AUDIO_PLL_SEQ_RETRY_LIMIT_EN` defined:
  - FAIL state and `MAX_RETRIES` comparison are compiled in.
  - `fail` behaves as above.
- Undefined:
  - Retries continue indefinitely; `fail` is tied 0; FAIL state is absent.
  - `retries` still counts and saturates at 15.

## Test plan
Use RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2.
- Reset release, then `locked`=1 at edge 10:
  - `pll_rst` high for edges 1–4;
  - `out_reset_n` rises at edge 20;
  - `retries`=0.
- `locked` held 0 (macro on): `pll_rst` pulses, then `retries` 1→2 after two 32-cycle timeouts, then `fail`=1 with `pll_rst` held high. Macro off: `retries` keeps counting to 15, `fail`=0.
- In RUN, drop `locked` at edge j:
  - at edge j+2, `out_reset_n`=0, `pll_rst`=1 and `lock_lost` high for one cycle;
  - re-lock gives release again after 2+8 cycles.
- In STAB, drop `locked` for 3 cycles after 5 stable cycles: returns to WAIT with no `retries` increment, and the release time restarts from re-lock.
- `locked` rising exactly on the WAIT timeout cycle: STAB entered, `retries` unchanged.
- Assert `reset_n` mid-STAB and mid-RUN: all outputs take their reset values asynchronously (before the next edge), and the full RST sequence repeats.
